// File: rtl/ncl_add4_sync_bridge.sv
// rtl/ncl_add4_sync_bridge.sv - clocked valid/ready bridge around a 4-bit dual-rail NCL adder
// Ports: clk, rst (synchronous, active-high)
//   in_valid/in_ready/in_a/in_b/in_cin : binary operand port
//   ncl_a/ncl_b/ncl_cin                : dual-rail drive, pair i = {true,false} at [2i+1:2i]
//   ncl_s/ncl_of                       : asynchronous dual-rail return from the adder
//   out_valid/out_ready/out_sum/out_of : binary result port
//   err                                : one-cycle pulse on timeout or illegal rail code
module ncl_add4_sync_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       in_cin,
  output logic [7:0] ncl_a,
  output logic [7:0] ncl_b,
  output logic [1:0] ncl_cin,
  input  logic [7:0] ncl_s,
  input  logic [1:0] ncl_of,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic       out_of,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_NULLW,
    S_DONE
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(SETTLE);

  state_t        state_q, state_d;
  logic [7:0]    ncl_a_q, ncl_a_d;
  logic [7:0]    ncl_b_q, ncl_b_d;
  logic [1:0]    ncl_cin_q, ncl_cin_d;
  logic [3:0]    out_sum_q, out_sum_d;
  logic          out_of_q, out_of_d;
  logic          err_q, err_d;
  logic          abort_q, abort_d;
  logic [9:0]    sync_q [SYNC_STAGES];
  logic [9:0]    sync_d [SYNC_STAGES];
  logic [9:0]    prev_q, prev_d;
  logic [CW-1:0] stable_q, stable_d;
  logic [TW-1:0] timer_q, timer_d;

  // Synced return code, packed as {ncl_of, ncl_s}.
  logic [9:0] code;
  logic       code_same;
  logic       settled;
  logic       all_complete;
  logic       any_illegal;
  logic       data_ok;
  logic       null_ok;
  logic       timer_hit;

  assign code = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = {ncl_of, ncl_s};
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Settle tracking: stable_q counts consecutive cycles in which the synced
  // code matched the previous cycle's code, so a code is trusted only after it
  // has been seen unchanged for SETTLE further cycles.
  always_comb begin
    prev_d    = code;
    code_same = (code == prev_q);
    if (!code_same) begin
      stable_d = '0;
    end else if (stable_q == C_MAX) begin
      stable_d = C_MAX;
    end else begin
      stable_d = stable_q + 1'b1;
    end
    settled = code_same && (stable_d == C_MAX);
  end

  always_comb begin
    all_complete = 1'b1;
    any_illegal  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (code[2*i] == code[2*i+1]) begin
        all_complete = 1'b0;
      end
      if (code[2*i] && code[2*i+1]) begin
        any_illegal = 1'b1;
      end
    end
  end

  assign data_ok   = all_complete && settled;
  assign null_ok   = (code == 10'd0) && settled;
  assign timer_hit = (timer_q == T_LAST);

  always_comb begin
    state_d   = state_q;
    ncl_a_d   = ncl_a_q;
    ncl_b_d   = ncl_b_q;
    ncl_cin_d = ncl_cin_q;
    out_sum_d = out_sum_q;
    out_of_d  = out_of_q;
    err_d     = 1'b0;
    abort_d   = abort_q;
    timer_d   = timer_hit ? timer_q : timer_q + 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int i = 0; i < 4; i++) begin
            ncl_a_d[2*i+1] = in_a[i];
            ncl_a_d[2*i]   = ~in_a[i];
            ncl_b_d[2*i+1] = in_b[i];
            ncl_b_d[2*i]   = ~in_b[i];
          end
          ncl_cin_d = {in_cin, ~in_cin};
          timer_d   = '0;
          abort_d   = 1'b0;
          state_d   = S_EVAL;
        end
      end

      S_EVAL: begin
        // A double-high pair is never a valid wavefront, so it aborts without
        // waiting for the code to settle.
        if (any_illegal || (!data_ok && timer_hit)) begin
          err_d     = 1'b1;
          abort_d   = 1'b1;
          ncl_a_d   = '0;
          ncl_b_d   = '0;
          ncl_cin_d = '0;
          timer_d   = '0;
          state_d   = S_NULLW;
        end else if (data_ok) begin
          for (int i = 0; i < 4; i++) begin
            out_sum_d[i] = code[2*i+1];
          end
          out_of_d  = code[9];
          abort_d   = 1'b0;
          ncl_a_d   = '0;
          ncl_b_d   = '0;
          ncl_cin_d = '0;
          timer_d   = '0;
          state_d   = S_NULLW;
        end
      end

      S_NULLW: begin
        if (null_ok) begin
          state_d = abort_q ? S_IDLE : S_DONE;
        end else if (timer_hit) begin
          err_d   = 1'b1;
          timer_d = '0;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ncl_a_q   <= '0;
      ncl_b_q   <= '0;
      ncl_cin_q <= '0;
      out_sum_q <= '0;
      out_of_q  <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      prev_q    <= '0;
      stable_q  <= '0;
      timer_q   <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ncl_a_q   <= ncl_a_d;
      ncl_b_q   <= ncl_b_d;
      ncl_cin_q <= ncl_cin_d;
      out_sum_q <= out_sum_d;
      out_of_q  <= out_of_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      timer_q   <= timer_d;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign ncl_a   = ncl_a_q;
  assign ncl_b   = ncl_b_q;
  assign ncl_cin = ncl_cin_q;
  assign out_sum = out_sum_q;
  assign out_of  = out_of_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ncl_add4_sync_bridge.sv
// tb/tb_ncl_add4_sync_bridge.sv - randomized bench with dual-rail adder model and result scoreboard
module tb_ncl_add4_sync_bridge;

  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_cin;
  logic [7:0] ncl_a;
  logic [7:0] ncl_b;
  logic [1:0] ncl_cin;
  logic [7:0] ncl_s;
  logic [1:0] ncl_of;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_sum;
  logic       out_of;
  logic       err;

  always #5 clk = ~clk;

  ncl_add4_sync_bridge #(
    .SYNC_STAGES(2),
    .SETTLE(2),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_cin(in_cin),
    .ncl_a(ncl_a),
    .ncl_b(ncl_b),
    .ncl_cin(ncl_cin),
    .ncl_s(ncl_s),
    .ncl_of(ncl_of),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_of(out_of),
    .err(err)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_in   = 0;
  int mode   = 0;   // adder model: 0 normal, 1 never completes, 2 sum bit 2 returns 2'b11
  int rdy_mode = 1; // out_ready: 0 low, 1 high, 2 random
  logic [2:0] dly = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: expected event not seen within bound at %0t", name, $time);
  endtask

  // {overflow, sum} of a signed 4-bit add with carry-in.
  function automatic logic [4:0] ref_add(input logic [3:0] a, input logic [3:0] b, input logic c);
    int sa, sb, tot;
    logic [4:0] r;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    tot = sa + sb + int'(c);
    r[3:0] = tot[3:0];
    r[4] = (tot > 7) || (tot < -8);
    return r;
  endfunction

  // Dual-rail adder: DATA out once every input pair is complete, otherwise NULL.
  function automatic logic [9:0] adder_target(input logic [7:0] ar, input logic [7:0] br,
                                              input logic [1:0] cr, input int md);
    logic [3:0] a, b;
    logic [4:0] res;
    logic ok;
    logic [9:0] r;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ar[2*i] == ar[2*i+1] || br[2*i] == br[2*i+1]) ok = 1'b0;
      a[i] = ar[2*i+1];
      b[i] = br[2*i+1];
    end
    if (cr[0] == cr[1]) ok = 1'b0;
    r = '0;
    if (ok && md != 1) begin
      res = ref_add(a, b, cr[1]);
      for (int i = 0; i < 4; i++) begin
        r[2*i+1] = res[i];
        r[2*i]   = ~res[i];
      end
      r[9] = res[4];
      r[8] = ~res[4];
      if (md == 2) r[5:4] = 2'b11;
    end
    return r;
  endfunction

  logic [9:0] tgt;
  logic [9:0] hist [0:4];
  assign tgt = adder_target(ncl_a, ncl_b, ncl_cin, mode);
  always @(posedge clk) begin
    hist[0] <= tgt;
    for (int k = 1; k < 5; k++) hist[k] <= hist[k-1];
  end
  assign {ncl_of, ncl_s} = (dly == 3'd0) ? tgt : hist[dly - 3'd1];

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard and per-cycle compare.
  logic [4:0] sb_q [$];
  logic [4:0] e;
  bit         busy = 0;
  bit         abort_pend = 0;
  bit         hold = 0;
  int         errs = 0;
  logic [3:0] h_sum;
  logic       h_of;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      busy = 0;
      abort_pend = 0;
      hold = 0;
    end else begin
      if (abort_pend && in_ready) begin
        check("abort_err_pulses", errs, 1);
        abort_pend = 0;
      end
      if (!abort_pend) begin
        check("in_ready", int'(in_ready), int'(!busy));
        check("err_quiet", int'(err), 0);
      end else if (err) begin
        errs++;
      end
      if (hold) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_sum", int'(out_sum), int'(h_sum));
        check("hold_of", int'(out_of), int'(h_of));
      end
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          fail("spurious_out_valid");
        end else if (out_ready) begin
          e = sb_q.pop_front();
          check("out_sum", int'(out_sum), int'(e[3:0]));
          check("out_of", int'(out_of), int'(e[4]));
          busy = 0;
        end
      end
      hold  = out_valid && !out_ready;
      h_sum = out_sum;
      h_of  = out_of;
      if (in_valid && in_ready) begin
        if (mode == 0) begin
          sb_q.push_back(ref_add(in_a, in_b, in_cin));
          busy = 1;
        end else begin
          abort_pend = 1;
          errs = 0;
        end
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic c, input int d);
    bit got;
    got = 0;
    in_a = a;
    in_b = b;
    in_cin = c;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        dly = 3'(d);
        t_in = cyc;
        break;
      end
    end
    if (!got) fail("send_accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input int es, input int eo, input int lat);
    bit got;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = 1;
        check("lit_sum", int'(out_sum), es);
        check("lit_of", int'(out_of), eo);
        if (lat >= 0) check("latency", cyc - t_in, lat);
        break;
      end
    end
    if (!got) fail("result_wait");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) fail(name);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_err(input string name, input int exp_at);
    bit got;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err) begin
        got = 1;
        if (exp_at >= 0) check({name, "_time"}, cyc - t_in, exp_at);
        check({name, "_null_a"}, int'(ncl_a), 0);
        check({name, "_null_cin"}, int'(ncl_cin), 0);
        break;
      end
    end
    if (!got) fail(name);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_ncl_a", int'(ncl_a), 0);
    check("rst_ncl_b", int'(ncl_b), 0);
    check("rst_ncl_cin", int'(ncl_cin), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_of", int'(out_of), 0);
    check("rst_err", int'(err), 0);
    @(posedge clk);
    #1;

    // Directed operand patterns with hand-computed results.
    send(4'd3, 4'd4, 1'b0, 0);
    check("enc_a", int'(ncl_a), int'(8'b01011010));
    check("enc_b", int'(ncl_b), int'(8'b01100101));
    check("enc_cin", int'(ncl_cin), int'(2'b01));
    expect_out(7, 0, 11);
    send(4'd7, 4'd1, 1'b0, 2);
    expect_out(8, 1, -1);
    send(4'd8, 4'd15, 1'b0, 3);
    expect_out(7, 1, -1);
    send(4'd5, 4'd10, 1'b1, 1);
    expect_out(0, 0, -1);

    // Back-pressure: result held while out_ready is low, next op waits.
    begin
      int rdy_seen;
      bit got;
      rdy_mode = 0;
      send(4'd2, 4'd3, 1'b0, 1);
      got = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (out_valid) begin
          got = 1;
          break;
        end
      end
      if (!got) fail("hold_valid_wait");
      @(posedge clk);
      #1;
      in_a = 4'd1;
      in_b = 4'd1;
      in_cin = 1'b1;
      in_valid = 1'b1;
      rdy_seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (in_ready) rdy_seen++;
      end
      check("hold_in_ready_count", rdy_seen, 0);
      @(posedge clk);
      #1;
      rdy_mode = 1;
      expect_out(5, 0, -1);
      send(4'd1, 4'd1, 1'b1, 0);
      expect_out(3, 0, -1);
    end

    // Adder never completes: timeout abort.
    mode = 1;
    send(4'd4, 4'd4, 1'b0, 1);
    wait_err("timeout", TIMEOUT + 1);
    wait_idle("timeout_idle");
    mode = 0;

    // Illegal 2'b11 on sum bit 2: abort.
    mode = 2;
    send(4'd6, 4'd1, 1'b0, 1);
    wait_err("illegal", -1);
    wait_idle("illegal_idle");
    mode = 0;

    // Reset in the middle of EVAL.
    mode = 1;
    send(4'd9, 4'd9, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ncl_a", int'(ncl_a), 0);
    check("midrst_ncl_b", int'(ncl_b), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    mode = 0;

    // Random operands, adder delays and back-pressure.
    rdy_mode = 2;
    for (int n = 0; n < 60; n++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), $urandom_range(0, 5));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 1;
    wait_idle("drain");
    check("scoreboard_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
